// File: rtl/etapa_mem_vectorial_pkg.sv
// Shared types and default widths for the vector memory stage.
package mem_vec_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_IMM_W  = 8;
  localparam int DEF_DEST_W = 3;
  localparam int DEF_CNT_W  = 5;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DRAIN  = 2'd2
  } state_t;

endpackage

// File: rtl/etapa_mem_vectorial_if.sv
// Request/response bus between the vector memory stage (master) and the data RAM (slave).
interface etapa_mem_vectorial_if
  import mem_vec_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);
  logic              mem_req;
  logic              mem_wr;
  logic [ADDR_W-1:0] dir_mem;
  logic [DATA_W-1:0] data;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_q;

  modport master (output mem_req, mem_wr, dir_mem, data, input mem_ready, mem_q);
  modport slave  (input mem_req, mem_wr, dir_mem, data, output mem_ready, mem_q);
endinterface

// File: rtl/etapa_mem_vectorial_gen_dir_mem.sv
// Address generator: current address plus persistent pointer, wrap at final_mem.
// MEM_STRIDE_EN defined: increment is the stride captured at load; otherwise fixed at 1.
module gen_dir_mem
  import mem_vec_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              advance,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] stride,
  input  logic [ADDR_W-1:0] final_mem,
  output logic [ADDR_W-1:0] addr,
  output logic [ADDR_W-1:0] ptr
);
  logic [ADDR_W-1:0] step;
  logic [ADDR_W-1:0] addr_next;

`ifdef MEM_STRIDE_EN
  logic [ADDR_W-1:0] stride_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stride_q <= '0;
    end else if (load) begin
      stride_q <= stride;
    end
  end

  assign step = stride_q;
`else
  // Port kept for interface stability; the value has no effect in this build.
  logic stride_unused;
  assign stride_unused = ^stride;
  assign step          = ADDR_W'(1);
`endif

  // Wrap decision looks at the address being issued now, not the incremented one.
  assign addr_next = (addr == final_mem) ? '0 : addr + step;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr <= '0;
      ptr  <= '0;
    end else if (load) begin
      addr <= base;
    end else if (advance) begin
      addr <= addr_next;
      ptr  <= addr_next;
    end
  end
endmodule

// File: rtl/etapa_mem_vectorial.sv
// Vector MEM stage: one memory request per element, read returns tagged with element index.
// Stride support is selected by MEM_STRIDE_EN inside gen_dir_mem (default: increment 1).
module etapa_mem_vectorial
  import mem_vec_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int IMM_W  = DEF_IMM_W,
  parameter int DEST_W = DEF_DEST_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              op_wr,
  input  logic              sel_mem,
  input  logic [IMM_W-1:0]  inmediate_in,
  input  logic [ADDR_W-1:0] stride,
  input  logic [CNT_W-1:0]  vlen,
  input  logic [ADDR_W-1:0] final_mem,
  input  logic              sel_data,
  input  logic [DATA_W-1:0] data1_in,
  input  logic [DATA_W-1:0] result_alu,
  input  logic [DEST_W-1:0] dir_dest_in,
  etapa_mem_vectorial_if.master mem,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic [CNT_W-1:0]  rd_idx,
  output logic [DEST_W-1:0] dir_dest_out,
  output logic              busy,
  output logic              done
);
  // state    | meaning
  // S_IDLE   | waiting for start; completion pulse is emitted here
  // S_ACCESS | one request per element, held stable while mem_ready is low
  // S_DRAIN  | load only: waiting for the last read return to reach rd_*

  state_t            state;
  logic              mem_req_q;
  logic              mem_wr_q;
  logic [CNT_W-1:0]  rem;
  logic [CNT_W-1:0]  idx;
  logic              p1_valid;
  logic              p1_last;
  logic [CNT_W-1:0]  p1_idx;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] dir_mem;
  logic [ADDR_W-1:0] ptr;
  logic              accept;
  logic              last_acc;
  logic              start_ok;

  assign accept   = mem_req_q & mem.mem_ready;
  assign last_acc = accept && (rem == CNT_W'(1));
  assign start_ok = start && (state == S_IDLE) && !busy;
  assign base     = sel_mem ? ADDR_W'(inmediate_in) : ptr;

  assign mem.mem_req = mem_req_q;
  assign mem.mem_wr  = mem_wr_q;
  assign mem.dir_mem = dir_mem;
  assign mem.data    = sel_data ? result_alu : data1_in;

  gen_dir_mem #(.ADDR_W(ADDR_W)) u_gen_dir_mem (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (start_ok && (vlen != '0)),
    .advance   (accept),
    .base      (base),
    .stride    (stride),
    .final_mem (final_mem),
    .addr      (dir_mem),
    .ptr       (ptr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      mem_req_q    <= 1'b0;
      mem_wr_q     <= 1'b0;
      rem          <= '0;
      idx          <= '0;
      p1_valid     <= 1'b0;
      p1_last      <= 1'b0;
      p1_idx       <= '0;
      rd_valid     <= 1'b0;
      rd_data      <= '0;
      rd_idx       <= '0;
      dir_dest_out <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      done     <= 1'b0;
      // Read return: accept at N, mem_q sampled at N+1, presented at N+2.
      p1_valid <= accept && !mem_wr_q;
      p1_last  <= last_acc;
      p1_idx   <= idx;
      rd_valid <= p1_valid;
      if (p1_valid) begin
        rd_data <= mem.mem_q;
        rd_idx  <= p1_idx;
      end

      case (state)
        S_IDLE: begin
          busy <= 1'b0;
          if (start_ok) begin
            dir_dest_out <= dir_dest_in;
            if (vlen == '0) begin
              done <= 1'b1;
            end else begin
              state     <= S_ACCESS;
              busy      <= 1'b1;
              mem_req_q <= 1'b1;
              mem_wr_q  <= op_wr;
              rem       <= vlen;
              idx       <= '0;
            end
          end
        end
        S_ACCESS: begin
          if (accept) begin
            idx <= idx + CNT_W'(1);
            rem <= rem - CNT_W'(1);
            if (last_acc) begin
              mem_req_q <= 1'b0;
              mem_wr_q  <= 1'b0;
              if (mem_wr_q) begin
                state <= S_IDLE;
                done  <= 1'b1;
              end else begin
                state <= S_DRAIN;
              end
            end
          end
        end
        S_DRAIN: begin
          if (p1_valid && p1_last) begin
            state <= S_IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_etapa_mem_vectorial.sv
// Scoreboard bench for etapa_mem_vectorial: expected requests, read returns and done cycles
// are queued at issue time and checked by an independent negedge monitor.
module tb_etapa_mem_vectorial;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        op_wr = 1'b0;
  logic        sel_mem = 1'b0;
  logic        sel_data = 1'b0;
  logic [7:0]  inmediate_in = 8'h00;
  logic [7:0]  stride = 8'h01;
  logic [7:0]  final_mem = 8'hFF;
  logic [4:0]  vlen = 5'd0;
  logic [31:0] data1_in = 32'h0;
  logic [31:0] result_alu = 32'h0;
  logic [2:0]  dir_dest_in = 3'd0;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic [4:0]  rd_idx;
  logic [2:0]  dir_dest_out;
  logic        busy;
  logic        done;

  etapa_mem_vectorial_if #(.DATA_W(32), .ADDR_W(8)) mif ();

  etapa_mem_vectorial dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .op_wr        (op_wr),
    .sel_mem      (sel_mem),
    .inmediate_in (inmediate_in),
    .stride       (stride),
    .vlen         (vlen),
    .final_mem    (final_mem),
    .sel_data     (sel_data),
    .data1_in     (data1_in),
    .result_alu   (result_alu),
    .dir_dest_in  (dir_dest_in),
    .mem          (mif),
    .rd_valid     (rd_valid),
    .rd_data      (rd_data),
    .rd_idx       (rd_idx),
    .dir_dest_out (dir_dest_out),
    .busy         (busy),
    .done         (done)
  );

  typedef struct packed {
    logic [7:0]  addr;
    logic        wr;
    logic [31:0] data;
  } acc_t;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  idx;
  } rd_t;

  acc_t acc_q[$];
  rd_t  rd_q[$];
  int   done_q[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  int   n_rdv = 0;
  acc_t m_acc;
  rd_t  m_rd;
  int   m_done;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] memfun(input logic [7:0] a);
    return {16'hC0DE, ~a, a};
  endfunction

  // RAM model: read data valid the cycle after an accepted read.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) mif.mem_q <= 32'h0;
    else if (mif.mem_req && mif.mem_ready && !mif.mem_wr) mif.mem_q <= memfun(mif.dir_mem);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic fail_evt(input string nm, input logic [31:0] act);
    n_chk++;
    $display("FAIL %s: got event with value %0h, expected none (cycle %0d)", nm, act, cyc);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (mif.mem_req && mif.mem_ready) begin
        if (acc_q.size() == 0) begin
          fail_evt("unexpected_req", 32'(mif.dir_mem));
        end else begin
          m_acc = acc_q.pop_front();
          chk("req_addr", 32'(mif.dir_mem), 32'(m_acc.addr));
          chk("req_wr", 32'(mif.mem_wr), 32'(m_acc.wr));
          if (m_acc.wr) chk("store_data", mif.data, m_acc.data);
        end
      end else if (mif.mem_req && acc_q.size() != 0) begin
        chk("held_addr", 32'(mif.dir_mem), 32'(acc_q[0].addr));
      end
      if (rd_valid) begin
        n_rdv++;
        if (rd_q.size() == 0) begin
          fail_evt("unexpected_rd_valid", rd_data);
        end else begin
          m_rd = rd_q.pop_front();
          chk("rd_data", rd_data, m_rd.data);
          chk("rd_idx", 32'(rd_idx), 32'(m_rd.idx));
        end
      end
      if (done) begin
        if (done_q.size() == 0) begin
          fail_evt("unexpected_done", 32'(cyc));
        end else begin
          m_done = done_q.pop_front();
          chk("done_cycle", 32'(cyc), 32'(m_done));
        end
      end
    end
  end

  // alist packs expected addresses, element 0 in the low byte.
  task automatic run_op(input logic wr, input logic sm, input logic sd,
                        input logic [7:0] imm, input logic [7:0] fin,
                        input logic [4:0] vl, input logic [2:0] dd,
                        input logic [63:0] alist, input int done_rel,
                        input int stall_from, input int stall_len, input int start_hold);
    int t0;
    acc_t e;
    rd_t r;
    @(posedge clk);
    #1;
    op_wr        = wr;
    sel_mem      = sm;
    sel_data     = sd;
    inmediate_in = imm;
    final_mem    = fin;
    vlen         = vl;
    dir_dest_in  = dd;
    data1_in     = {16'h1111, 3'b000, vl, imm};
    result_alu   = {16'h2222, imm, 3'b000, vl};
    start        = 1'b1;
    t0           = cyc;
    for (int i = 0; i < int'(vl); i++) begin
      e.addr = alist[8*i +: 8];
      e.wr   = wr;
      e.data = sd ? result_alu : data1_in;
      acc_q.push_back(e);
      if (!wr) begin
        r.data = memfun(e.addr);
        r.idx  = 5'(i);
        rd_q.push_back(r);
      end
    end
    done_q.push_back(t0 + done_rel);
    for (int k = 1; k <= 80; k++) begin
      @(posedge clk);
      #1;
      start         = (k < start_hold);
      mif.mem_ready = !(k >= stall_from && k < stall_from + stall_len);
      if (k == 1) chk("busy_cycle1", 32'(busy), 32'(vl != 5'd0));
      if (k >= 2 && !busy) break;
      if (k == 80) fail_evt("timeout_busy", 32'(busy));
    end
    start         = 1'b0;
    mif.mem_ready = 1'b1;
    chk("req_left", 32'(acc_q.size()), 32'd0);
    chk("rd_left", 32'(rd_q.size()), 32'd0);
    chk("done_left", 32'(done_q.size()), 32'd0);
    chk("dir_dest_out", 32'(dir_dest_out), 32'(dd));
    acc_q.delete();
    rd_q.delete();
    done_q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    mif.mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_req", 32'(mif.mem_req), 32'd0);
    chk("rst_mem_wr", 32'(mif.mem_wr), 32'd0);
    chk("rst_dir_mem", 32'(mif.dir_mem), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rd_data", rd_data, 32'd0);
    chk("rst_rd_idx", 32'(rd_idx), 32'd0);
    chk("rst_dir_dest", 32'(dir_dest_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;

    //     wr    sm    sd    imm    fin    vl    dd    addresses         done stall  hold
    run_op(1'b1, 1'b1, 1'b1, 8'h10, 8'hFF, 5'd4, 3'd5, 64'h13121110,      5, 0, 0, 1);
    run_op(1'b0, 1'b0, 1'b0, 8'h00, 8'hFF, 5'd3, 3'd2, 64'h161514,        5, 0, 0, 1);
    run_op(1'b1, 1'b1, 1'b0, 8'h06, 8'h07, 5'd4, 3'd7, 64'h01000706,      5, 0, 0, 1);
    run_op(1'b0, 1'b0, 1'b1, 8'h00, 8'hFF, 5'd2, 3'd3, 64'h0302,          7, 2, 3, 1);
    run_op(1'b1, 1'b0, 1'b0, 8'h00, 8'hFF, 5'd0, 3'd6, 64'h0,             1, 0, 0, 1);
    run_op(1'b1, 1'b0, 1'b0, 8'h00, 8'hFF, 5'd2, 3'd1, 64'h0504,          3, 0, 0, 3);
    run_op(1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 5'd3, 3'd4, 64'h000000,        4, 0, 0, 1);
    stride = 8'h04;
`ifdef MEM_STRIDE_EN
    run_op(1'b1, 1'b1, 1'b0, 8'hF8, 8'hFF, 5'd3, 3'd0, 64'h00FCF8,        4, 0, 0, 1);
`else
    run_op(1'b1, 1'b1, 1'b0, 8'hF8, 8'hFF, 5'd3, 3'd0, 64'hFAF9F8,        4, 0, 0, 1);
`endif
    stride = 8'h01;

    // Reset in the middle of a load: pending returns must vanish, pointer back to 0.
    @(posedge clk);
    #1;
    op_wr        = 1'b0;
    sel_mem      = 1'b1;
    inmediate_in = 8'h40;
    final_mem    = 8'hFF;
    vlen         = 5'd4;
    start        = 1'b1;
    m_acc.addr   = 8'h40;
    m_acc.wr     = 1'b0;
    m_acc.data   = 32'h0;
    acc_q.push_back(m_acc);
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    acc_q.delete();
    rd_q.delete();
    done_q.delete();
    #1;
    chk("midrst_mem_req", 32'(mif.mem_req), 32'd0);
    chk("midrst_dir_mem", 32'(mif.dir_mem), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_rd_valid", 32'(rd_valid), 32'd0);
    chk("midrst_rd_data", rd_data, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    n_rdv = 0;
    repeat (5) @(posedge clk);
    #1;
    chk("rdv_after_rst", 32'(n_rdv), 32'd0);
    chk("busy_after_rst", 32'(busy), 32'd0);

    run_op(1'b0, 1'b0, 1'b0, 8'h00, 8'hFF, 5'd1, 3'd2, 64'h00,            3, 0, 0, 1);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/etapa_mem_vectorial.md
# etapa_mem_vectorial

Parametrised vector memory stage. It replaces the single-address MEM stage with a sequencer that issues one memory request per vector element. It generates addresses from an immediate base or a persistent pointer, with stride and wrap at a programmable limit, and handles memory back-pressure. Read data returns tagged with its element index. It sits between the EX/MEM pipeline register and the data RAM and feeds MEM/WB.

## Interface
- DATA_W, 32, element/data width
- ADDR_W, 8, memory address width
- IMM_W, 8, immediate width (IMM_W ≤ ADDR_W)
- DEST_W, 3, destination register index width
- CNT_W, 5, element count width (max vlen 2^CNT_W−1)
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  launch operation; sampled only in IDLE
- op_wr  in  1  1 = store, 0 = load
- sel_mem  in  1  1 = base from inmediate_in (zero-extended), 0 = base from pointer
- inmediate_in  in  IMM_W  immediate base address
- stride  in  ADDR_W  address increment; used only with MEM_STRIDE_EN
- vlen  in  CNT_W  element count
- final_mem  in  ADDR_W  wrap limit address
- sel_data  in  1  store source: 0 = data1_in, 1 = result_alu
- data1_in, result_alu  in  DATA_W  store data candidates, one element per accepted request
- dir_dest_in  in  DEST_W  destination register
- mem_ready  in  1  memory accepts the request this cycle
- mem_q  in  DATA_W  read data, valid the cycle after an accepted read
- mem_req, mem_wr  out  1  request valid / write strobe
- dir_mem  out  ADDR_W  request address
- data  out  DATA_W  store data = sel_data mux (combinational)
- rd_valid  out  1  registered read data valid
- rd_data  out  DATA_W  registered read element
- rd_idx  out  CNT_W  element index of rd_data
- dir_dest_out  out  DEST_W  destination captured at start
- busy, done  out  1  operation active / one-cycle completion pulse

## Operation
- States:
  - IDLE: start → ACCESS, or → IDLE with done if vlen=0.
  - ACCESS: issues requests. After the last request is accepted: store → IDLE with done; load → DRAIN.
  - DRAIN: → IDLE when the last rd_valid is emitted; done pulses in that cycle.
- On start, capture addr = sel_mem ? {0, inmediate_in} : ptr. Also capture op_wr, vlen, dir_dest_in and stride.
- Accept = mem_req & mem_ready. On accept: idx+1, and addr_next = (addr == final_mem) ? 0 : (addr + stride) mod 2^ADDR_W.
- ptr is updated to addr_next on every accept. ptr persists across operations and resets to 0.
- mem_ready low: mem_req, dir_mem and mem_wr are held stable; no state change.
- start while busy is ignored. start with vlen=0 issues no request and leaves ptr unchanged.
- Loads: each read accepted at cycle N is captured from mem_q at N+1 and presented on rd_valid/rd_data/rd_idx at N+2.
- Reset (including mid-operation) aborts immediately, returns to IDLE and discards pending read returns.

## Timing
- Reset values: mem_req=0, mem_wr=0, dir_mem=0, rd_valid=0, rd_data=0, rd_idx=0, dir_dest_out=0, busy=0, done=0, ptr=0, state IDLE.
- start at cycle 0: mem_req high from cycle 1 (registered); busy high from cycle 1 until the cycle after done.
- Store with no stall: vlen requests in cycles 1..vlen; done in cycle vlen+1.
- Load with no stall: last rd_valid in cycle vlen+2, with done in the same cycle.
- Wrap compare uses the current address. final_mem=0 forces every next address to 0.

## Configuration
- MEM_STRIDE_EN defined: stride input used, captured at start.
- MEM_STRIDE_EN undefined: stride ignored, increment fixed at 1. The port remains present for interface stability.

## Structure
- Package mem_vec_pkg: state enum (S_IDLE, S_ACCESS, S_DRAIN) and default width constants.
- Sub-module gen_dir_mem: holds the address and pointer registers, the wrap compare, and the stride add with load/advance controls.
- The top level holds the FSM, element counter, read return pipeline and data mux.

## Test plan
- Store, sel_mem=1, imm=0x10, vlen=4, stride 1, final_mem=0xFF, ready=1 → writes at 0x10..0x13 in cycles 1–4; done in cycle 5; ptr=0x14.
- Load continuing from ptr=0x14, vlen=3 → reads at 0x14..0x16; rd_idx 0,1,2 with matching mem_q values; done with the last rd_valid in cycle 5.
- Wrap: base 0x06, final_mem=0x07, vlen=4 → addresses 0x06, 0x07, 0x00, 0x01.
- Stride (MEM_STRIDE_EN): base 0xF8, stride 4, vlen=3, final_mem=0xFF → addresses 0xF8, 0xFC, 0x00 (modular overflow).
- Back-pressure: mem_ready low for 3 cycles on the second element → address held; exactly vlen accepts; done delayed 3 cycles.
- start with vlen=0 → done at cycle 1, no mem_req. Reset asserted mid-load → all outputs at reset values, no rd_valid afterwards.
